alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU interface: decodes RV32I OP, OP-IMM, LUI and AUIPC instructions into alu_op, operand1 and operand2.
//  Registers the decoded payload for the execute stage. Has a 2-entry skid buffer with valid/ready on both sides.
//  Sits between register-file read (decode) and the combinational ALU in execute.
// PARAMETERS
//  XLEN            32  datapath width; only 32 is supported
//  SUPPRESS_X0_WE  1   1: force out_rd_we=0 when rd==x0
// PORTS
//  clk           in   1     single clock; all state on rising edge
//  rst_n         in   1     synchronous, active-low reset
//  flush         in   1     pipeline kill (branch/trap redirect)
//  in_valid      in   1     instruction + register data valid
//  in_ready      out  1     stage can accept this cycle
//  in_instr      in   32    raw instruction
//  in_pc         in   32    instruction PC (AUIPC)
//  in_rs1_data   in   32    rs1 value
//  in_rs2_data   in   32    rs2 value
//  out_valid     out  1     payload valid toward execute
//  out_ready     in   1     execute consumes payload
//  out_alu_op    out  4     ALU op code
//  out_operand1  out  32    ALU operand1
//  out_operand2  out  32    ALU operand2
//  out_rd        out  5     destination register
//  out_rd_we     out  1     writeback enable
//  out_illegal   out  1     present only with ALU_ISSUE_ILLEGAL_EN
// BEHAVIOUR
//  alu_op codes:
//    ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
//  Decode is keyed on opcode (instr[6:0]); f3 = instr[14:12]:
//    OP 0110011:     op1=rs1, op2=rs2, alu_op={instr[30], f3}.
//                    Legal iff funct7==0000000, or funct7==0100000 with f3 in {000, 101}.
//    OP-IMM 0010011: op1=rs1, op2=sext(instr[31:20]).
//                    f3=001/101: op2={27'b0, instr[24:20]}, alu_op={instr[30], f3}.
//                    SLLI legal iff funct7==0; SRLI/SRAI legal iff funct7 in {0000000, 0100000}.
//                    All other f3: alu_op={1'b0, f3}.
//    LUI 0110111:    op1=0, op2={instr[31:12], 12'b0}, alu_op=ADD.
//    AUIPC 0010111:  op1=in_pc, op2={instr[31:12], 12'b0}, alu_op=ADD.
//    Other opcodes:  illegal.
//  Illegal payload: alu_op=0000, op1=op2=0, rd_we=0.
//  Legal payload: out_rd=instr[11:7], out_rd_we=1 (0 if rd==0 and SUPPRESS_X0_WE=1).
//  Skid buffer:
//    Holds a main entry (drives out_*) and a skid entry. in_ready = ~skid_valid, registered, never a function of out_ready.
//    Accept = in_valid & in_ready.
//    When main is empty or draining, the accept loads main.
//    When main is stalled (out_valid & ~out_ready), the accept loads skid.
//    When main drains and skid is full, skid moves to main on the same edge. Order is strictly FIFO.
//    Latency: accept to out_valid is 1 cycle. Full throughput with out_ready held high.
//    Payload is stable while out_valid & ~out_ready.
//  Reset (rst_n low at edge):
//    Both entries invalid; out_valid=0; payload outputs=0 (out_illegal=0).
//    in_ready=0 while rst_n is low, 1 from the first cycle after release. Reset dominates flush.
//  Flush:
//    Invalidates both entries at the edge. A same-cycle accept is discarded.
//    out_valid=0 and in_ready=1 on the next cycle. Flush dominates accept and drain.
// CONFIGURATION
//  ALU_ISSUE_ILLEGAL_EN defined:
//    out_illegal port exists. Illegal instructions flow through as normal entries with out_illegal=1 and the safe payload.
//  ALU_ISSUE_ILLEGAL_EN undefined:
//    No out_illegal port. Illegal instructions are accepted and silently dropped; they never produce out_valid.
// STRUCTURE
//  Shared package (alu_pkg): ALU_ADD..ALU_AND localparams (4-bit), opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
//  The ALU and this stage both use the package.
//  One sub-module, alu_issue_decode: purely combinational, instr/pc/rs1/rs2 -> {alu_op, op1, op2, rd, rd_we, illegal}.
//  The top holds the skid buffer, handshake and flush logic.
// TESTING
//  1. Reset, then ADD x3,x1,x2 with rs1=5, rs2=7 and out_ready=1 -> next cycle out_valid=1, alu_op=0000, op1=5, op2=7, rd=3, rd_we=1.
//  2. SRAI x5,x6,4 (0x40435293), rs1=0x80000000 -> alu_op=1101, op2=0x00000004.
//     ADDI with imm=-1 -> op2=0xFFFFFFFF, alu_op=0000.
//  3. AUIPC x1,0x12345 at pc=0x100 -> op1=0x100, op2=0x12345000.
//     LUI x0,1 -> rd_we=0.
//  4. Back-to-back A,B,C with out_ready=0 for 3 cycles: A in main, B in skid, in_ready=0, C held.
//     Release out_ready -> A,B,C in order, no loss or duplication.
//  5. Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; nothing from before the flush appears.
//  6. Opcode 0x7F: with macro -> out_illegal=1, rd_we=0, alu_op=0; without macro -> no out_valid. rst_n low mid-stall -> all clear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcodes and the issue payload.
// Used by both the ALU issue stage and the execute-side ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rd_we;
  } alu_payload_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into ALU op and operands.
// Illegal encodings yield a safe payload (ADD, zero operands, no writeback).
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int SUPPRESS_X0_WE = 1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output alu_payload_t    payload,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic        legal;
  logic [3:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        f7_zero;
  logic        f7_alt;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rd      = instr[11:7];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    op1    = '0;
    op2    = '0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        op1    = rs1_data;
        op2    = rs2_data;
        alu_op = {instr[30], f3};
        legal  = f7_zero |
                 (f7_alt & ((f3 == 3'b000) | (f3 == 3'b101)));
      end
      (opc == OPC_OP_IMM): begin
        op1    = rs1_data;
        op2    = sext12(instr[31:20]);
        alu_op = {1'b0, f3};
        legal  = 1'b1;
        if (f3 == 3'b001) begin
          op2    = {27'b0, instr[24:20]};
          alu_op = {instr[30], f3};
          legal  = f7_zero;
        end else if (f3 == 3'b101) begin
          op2    = {27'b0, instr[24:20]};
          alu_op = {instr[30], f3};
          legal  = f7_zero | f7_alt;
        end
      end
      (opc == OPC_LUI): begin
        op2   = {instr[31:12], 12'b0};
        legal = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        op1   = pc;
        op2   = {instr[31:12], 12'b0};
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    payload = '0;
    if (legal) begin
      payload.alu_op = alu_op;
      payload.op1    = op1;
      payload.op2    = op2;
      payload.rd     = rd;
      payload.rd_we  = ~((SUPPRESS_X0_WE != 0) && (rd == 5'd0));
    end
  end

  assign illegal = ~legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, register and skid-buffer ALU payloads.
// ALU_ISSUE_ILLEGAL_EN: pass illegal ops through flagged, else drop them.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int SUPPRESS_X0_WE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [31:0]     out_operand1,
  output logic [31:0]     out_operand2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  alu_payload_t dec;
  alu_payload_t main_q;
  alu_payload_t skid_q;
  logic         dec_illegal;
  logic         main_v;
  logic         skid_v;
  logic         rdy_q;
  logic         acc;
  logic         load;
  logic         drain;
  logic         main_from_skid;
  logic         main_from_in;
  logic         skid_from_in;

  alu_issue_decode #(
    .XLEN           (XLEN),
    .SUPPRESS_X0_WE (SUPPRESS_X0_WE)
  ) u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .payload  (dec),
    .illegal  (dec_illegal)
  );

  assign acc = in_valid & rdy_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign load = acc;
`else
  // Illegal ops are consumed here and never reach execute.
  assign load = acc & ~dec_illegal;
`endif
  assign drain          = ~main_v | out_ready;
  assign main_from_skid = drain & skid_v;
  assign main_from_in   = drain & ~skid_v & load;
  assign skid_from_in   = ~drain & load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      if (main_from_skid) begin
        main_q <= skid_q;
      end else if (main_from_in) begin
        main_q <= dec;
      end
      if (skid_from_in) begin
        skid_q <= dec;
      end
      if (drain) begin
        main_v <= skid_v | load;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end else if (load) begin
        skid_v <= 1'b1;
        rdy_q  <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic main_ill;
  logic skid_ill;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_ill <= 1'b0;
      skid_ill <= 1'b0;
    end else if (!flush) begin
      if (main_from_skid) begin
        main_ill <= skid_ill;
      end else if (main_from_in) begin
        main_ill <= dec_illegal;
      end
      if (skid_from_in) begin
        skid_ill <= dec_illegal;
      end
    end
  end

  assign out_illegal = main_ill;
`endif

  assign in_ready     = rdy_q;
  assign out_valid    = main_v;
  assign out_alu_op   = main_q.alu_op;
  assign out_operand1 = main_q.op1;
  assign out_operand2 = main_q.op2;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;

endmodule
